inst_sram_resp: RTL and testbench
=================================

# inst_sram_resp

Synchronous single-port SRAM responder for the core's SRAM-style memory port: it is the memory side of the `inst_sram_*` interface driven by the fetch stage, and is reusable for the data port. It accepts one access per cycle, performs byte-enabled writes and read-first reads, and returns read data after a fixed, parameterised latency. It also validates the address window and counts illegal accesses. It is used in simulation tops and the FPGA wrapper in place of a vendor RAM macro.

## Interface
- `ADDR_BASE`, default 32'h1c00_0000: byte address of word 0.
- `DEPTH_LOG2`, default 14: log2 of the word count (16384 words, 64 KiB).
- `RD_LAT`, default 1: read latency in cycles; legal values 1 to 4.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `inst_sram_en`, input, 1: access request this cycle.
- `inst_sram_we`, input, 4: byte write enables; bit i controls byte lane i; 0 means read.
- `inst_sram_addr`, input, 32: byte address.
- `inst_sram_wdata`, input, 32: write data.
- `inst_sram_rdata`, output, 32: response data.
- `rdata_valid`, output, 1: a response is presented this cycle.
- `rdata_addr`, output, 32: address of the access being responded to.
- `addr_err`, output, 1: the presented response came from an illegal access.
- `err_cnt`, output, 16: saturating count of illegal accesses.

## Operation
- **Legality.** An access is legal iff all of the following hold:
  - `addr >= ADDR_BASE`
  - `addr < ADDR_BASE + (4 << DEPTH_LOG2)`
  - `addr[1:0] == 0`
- **Indexing.** Word index = `(addr - ADDR_BASE) >> 2`, truncated to `DEPTH_LOG2` bits. The address window does not wrap.
- **Legal write** (`en=1`, `we!=0`): lanes with `we[i]=1` are written from `wdata[8i+7:8i]`; other lanes are unchanged. The access still produces a response carrying the **old** word (read-first).
- **Legal read** (`en=1`, `we=0`): the response carries the stored word.
- **Illegal access:**
  - no memory write occurs;
  - the response carries 32'h0000_0000 with `addr_err=1`;
  - `err_cnt` increments by 1 at the cycle the access is sampled, saturating at 16'hFFFF.
- **Idle** (`en=0`): no response is generated. `inst_sram_rdata`, `rdata_addr` and `addr_err` hold their last values, and `rdata_valid=0`.
- **Pipeline structure.** A response pipeline of `RD_LAT` stages carries {valid, data, addr, err}.
  - Stage 1 is the RAM output register.
  - Stages 2 to `RD_LAT` are plain delay registers.
  - Outputs come from the last stage.
- **No backpressure.** The block accepts a new access every cycle. Responses emerge in request order, one per accepted access, with no reordering or dropping.
- **Write then read.** A write sampled at edge N followed by a read of the same word sampled at edge N+1 returns the new data.
- **Memory initialisation.** Contents are not reset; the simulation top preloads them. Uninitialised words read as X in simulation.
- **`RD_LAT` range.** A value outside 1 to 4 is a configuration error; the block asserts this under simulation.

## Timing
- **Request sampling.** A request is sampled at rising edge N.
- **Response latency.** `rdata_valid`, `inst_sram_rdata`, `rdata_addr` and `addr_err` for that request are visible during the cycle following edge N+RD_LAT-1. With `RD_LAT=1`, data appears the cycle after the request, which is standard synchronous SRAM behaviour.
- **Reset values.** On any edge with `reset=1`:
  - all pipeline valid bits are cleared and `rdata_valid=0`;
  - `inst_sram_rdata`, `rdata_addr` and `err_cnt` are 0;
  - `addr_err=0`.
- **Reset and requests.** A request sampled in the same cycle as `reset=1` is ignored: no write, no count, no response.
- **Reset mid-operation.** In-flight responses are discarded; memory contents written before the reset remain.
- **Simultaneous `en` with `we` partial.** Only the enabled lanes change; the response is still read-first.
- **Error counter at saturation.** At 16'hFFFF, further illegal accesses leave `err_cnt` unchanged, while `addr_err` still pulses with each response.

## Test plan
- **Reset and first fetch.** Preload word 0 = 32'h0340_0000, `RD_LAT=1`. Release reset, then issue a read at 32'h1c00_0000 → next cycle `rdata_valid=1`, `rdata=32'h0340_0000`, `rdata_addr=32'h1c00_0000`, `addr_err=0`.
- **Byte write, read-first.** Word 1 = 32'h1122_3344. Write 32'hAABB_CCDD with `we=4'b0101` at 32'h1c00_0004 → that response returns 32'h1122_3344. A read on the next cycle returns 32'h11BB_33DD.
- **Back-to-back with `RD_LAT=3`.** Reads at 0x1c000000, 0x1c000004 and 0x1c000008 on consecutive cycles, then `en=0` → three valid responses on cycles 3, 4 and 5 in order. Afterwards `rdata_valid=0` and `rdata` holds the third word.
- **Illegal addresses.** Accesses to 32'h1bff_fffc, 32'h1c01_0000 and 32'h1c00_0002 (write, `we=4'hF`) → each response has `rdata=0` and `addr_err=1`; `err_cnt=3`; memory is unchanged.
- **Counter saturation.** Force `err_cnt` to 16'hFFFE, then issue 3 illegal accesses → `err_cnt` reads 16'hFFFF and stays there.
- **Reset mid-flight with `RD_LAT=2`.** Issue a read, assert `reset` on the next cycle → no `rdata_valid` pulse. After release, a read of the same address returns the preloaded word.

Source files
------------

// File: rtl/inst_sram_resp_if.sv
// SRAM-style memory port between the fetch (or data) stage and its responder.
// The master drives requests; the slave returns pipelined responses and error status.
interface inst_sram_resp_if;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        rdata_valid;
  logic [31:0] rdata_addr;
  logic        addr_err;
  logic [15:0] err_cnt;

  modport master (
    output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    input  inst_sram_rdata, rdata_valid, rdata_addr, addr_err, err_cnt
  );

  modport slave (
    input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    output inst_sram_rdata, rdata_valid, rdata_addr, addr_err, err_cnt
  );
endinterface

// File: rtl/inst_sram_resp.sv
// Synchronous single-port SRAM responder: byte-enabled writes, read-first reads,
// fixed RD_LAT response pipeline, address window check and saturating error count.
module inst_sram_resp #(
  parameter logic [31:0] ADDR_BASE  = 32'h1c00_0000,
  parameter int unsigned DEPTH_LOG2 = 14,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic            clk,
  input  logic            reset,
  inst_sram_resp_if.slave bus
);
  localparam int unsigned Depth  = 1 << DEPTH_LOG2;
  localparam logic [32:0] WinEnd = {1'b0, ADDR_BASE} + (33'd4 << DEPTH_LOG2);

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("inst_sram_resp: RD_LAT must be in 1..4");
  end

  logic [31:0]           r_mem [Depth];
  logic                  r_vld  [RD_LAT];
  logic [31:0]           r_data [RD_LAT];
  logic [31:0]           r_addr [RD_LAT];
  logic                  r_err  [RD_LAT];
  logic [15:0]           r_err_cnt;

  logic [32:0]           w_addr_ext;
  logic [31:0]           w_offset;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_legal;
  logic                  w_write;

  // 33-bit compare so the window end cannot wrap past 2^32.
  assign w_addr_ext = {1'b0, bus.inst_sram_addr};
  assign w_legal    = (w_addr_ext >= {1'b0, ADDR_BASE}) && (w_addr_ext < WinEnd) &&
                      (bus.inst_sram_addr[1:0] == 2'b00);
  assign w_offset   = bus.inst_sram_addr - ADDR_BASE;
  assign w_idx      = DEPTH_LOG2'(w_offset >> 2);
  assign w_write    = !reset && bus.inst_sram_en && w_legal && (bus.inst_sram_we != 4'b0000);

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_write && bus.inst_sram_we[i]) begin
        r_mem[w_idx][8*i +: 8] <= bus.inst_sram_wdata[8*i +: 8];
      end
    end
  end

  // Stage 0 is the RAM output register; later stages only advance on a valid beat,
  // so the output fields hold their last response while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < RD_LAT; k++) begin
        r_vld[k]  <= 1'b0;
        r_data[k] <= '0;
        r_addr[k] <= '0;
        r_err[k]  <= 1'b0;
      end
    end else begin
      r_vld[0] <= bus.inst_sram_en;
      if (bus.inst_sram_en) begin
        r_data[0] <= w_legal ? r_mem[w_idx] : 32'h0000_0000;
        r_addr[0] <= bus.inst_sram_addr;
        r_err[0]  <= !w_legal;
      end
      for (int k = 1; k < RD_LAT; k++) begin
        r_vld[k] <= r_vld[k-1];
        if (r_vld[k-1]) begin
          r_data[k] <= r_data[k-1];
          r_addr[k] <= r_addr[k-1];
          r_err[k]  <= r_err[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_cnt <= '0;
    end else if (bus.inst_sram_en && !w_legal && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign bus.inst_sram_rdata = r_data[RD_LAT-1];
  assign bus.rdata_valid     = r_vld[RD_LAT-1];
  assign bus.rdata_addr      = r_addr[RD_LAT-1];
  assign bus.addr_err        = r_err[RD_LAT-1];
  assign bus.err_cnt         = r_err_cnt;
endmodule

// File: tb/tb_inst_sram_resp.sv
// Drives three responders (RD_LAT 1, 2, 3) with one stimulus stream and checks them
// every cycle against a history-based model, plus literal checks from the test plan.
module tb_inst_sram_resp;
  localparam logic [31:0] Base   = 32'h1c00_0000;
  localparam longint      WinLen = 4 << 14;
  localparam int          HistN  = 4096;

  logic        clk = 1'b0;
  logic        s_rst = 1'b1;
  logic        s_en = 1'b0;
  logic [3:0]  s_we = 4'h0;
  logic [31:0] s_addr = '0;
  logic [31:0] s_wdata = '0;

  always #5 clk = ~clk;

  inst_sram_resp_if if1 ();
  inst_sram_resp_if if2 ();
  inst_sram_resp_if if3 ();

  assign if1.inst_sram_en = s_en;  assign if1.inst_sram_we = s_we;
  assign if1.inst_sram_addr = s_addr;  assign if1.inst_sram_wdata = s_wdata;
  assign if2.inst_sram_en = s_en;  assign if2.inst_sram_we = s_we;
  assign if2.inst_sram_addr = s_addr;  assign if2.inst_sram_wdata = s_wdata;
  assign if3.inst_sram_en = s_en;  assign if3.inst_sram_we = s_we;
  assign if3.inst_sram_addr = s_addr;  assign if3.inst_sram_wdata = s_wdata;

  inst_sram_resp #(.ADDR_BASE(Base), .DEPTH_LOG2(14), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(s_rst), .bus(if1.slave));
  inst_sram_resp #(.ADDR_BASE(Base), .DEPTH_LOG2(14), .RD_LAT(2)) dut2 (
    .clk(clk), .reset(s_rst), .bus(if2.slave));
  inst_sram_resp #(.ADDR_BASE(Base), .DEPTH_LOG2(14), .RD_LAT(3)) dut3 (
    .clk(clk), .reset(s_rst), .bus(if3.slave));

  logic        o_valid [1:3];
  logic [31:0] o_data  [1:3];
  logic [31:0] o_addr  [1:3];
  logic        o_err   [1:3];
  logic [15:0] o_cnt   [1:3];
  assign o_valid[1] = if1.rdata_valid; assign o_data[1] = if1.inst_sram_rdata;
  assign o_addr[1] = if1.rdata_addr; assign o_err[1] = if1.addr_err; assign o_cnt[1] = if1.err_cnt;
  assign o_valid[2] = if2.rdata_valid; assign o_data[2] = if2.inst_sram_rdata;
  assign o_addr[2] = if2.rdata_addr; assign o_err[2] = if2.addr_err; assign o_cnt[2] = if2.err_cnt;
  assign o_valid[3] = if3.rdata_valid; assign o_data[3] = if3.inst_sram_rdata;
  assign o_addr[3] = if3.rdata_addr; assign o_err[3] = if3.addr_err; assign o_cnt[3] = if3.err_cnt;

  int n_chk = 0;
  int n_fail = 0;

  // Model state: memory by word index, per-edge response history, expected outputs per latency.
  logic [31:0] m_mem [int];
  bit          h_valid [HistN];
  bit          h_known [HistN];
  logic [31:0] h_data  [HistN];
  logic [31:0] h_addr  [HistN];
  bit          h_err   [HistN];
  int          e_n = -1;
  int          last_rst = -1;
  logic [15:0] m_cnt = '0;
  bit          x_valid [1:3];
  bit          x_known [1:3];
  logic [31:0] x_data  [1:3];
  logic [31:0] x_addr  [1:3];
  bit          x_err   [1:3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    longint a;
    int     idx;
    int     k;
    bit     legal;
    e_n++;
    h_valid[e_n] = 1'b0;
    if (s_rst) begin
      last_rst = e_n;
      m_cnt = '0;
    end else if (s_en) begin
      a = longint'(s_addr);
      legal = (a >= longint'(Base)) && (a < longint'(Base) + WinLen) && (s_addr[1:0] == 2'b00);
      h_valid[e_n] = 1'b1;
      h_addr[e_n]  = s_addr;
      h_err[e_n]   = !legal;
      if (legal) begin
        idx = int'((a - longint'(Base)) / 4);
        h_known[e_n] = m_mem.exists(idx);
        h_data[e_n]  = h_known[e_n] ? m_mem[idx] : 32'h0;
        if (s_we == 4'hF) m_mem[idx] = s_wdata;
        else if (s_we != 4'h0 && m_mem.exists(idx)) begin
          for (int i = 0; i < 4; i++)
            if (s_we[i]) m_mem[idx][8*i +: 8] = s_wdata[8*i +: 8];
        end
      end else begin
        h_known[e_n] = 1'b1;
        h_data[e_n]  = 32'h0;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
    end
    for (int l = 1; l <= 3; l++) begin
      k = e_n - l + 1;
      if (s_rst) begin
        x_valid[l] = 1'b0; x_known[l] = 1'b1; x_data[l] = '0; x_addr[l] = '0; x_err[l] = 1'b0;
      end else if (k < 0 || last_rst >= k || !h_valid[k]) begin
        x_valid[l] = 1'b0;
      end else begin
        x_valid[l] = 1'b1; x_known[l] = h_known[k]; x_data[l] = h_data[k];
        x_addr[l] = h_addr[k]; x_err[l] = h_err[k];
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  initial forever begin
    @(negedge clk);
    for (int l = 1; l <= 3; l++) begin
      chk($sformatf("lat%0d rdata_valid", l), 32'(o_valid[l]), 32'(x_valid[l]));
      chk($sformatf("lat%0d err_cnt", l), 32'(o_cnt[l]), 32'(m_cnt));
      chk($sformatf("lat%0d rdata_addr", l), o_addr[l], x_addr[l]);
      chk($sformatf("lat%0d addr_err", l), 32'(o_err[l]), 32'(x_err[l]));
      if (x_known[l]) chk($sformatf("lat%0d rdata", l), o_data[l], x_data[l]);
    end
  end

  task automatic step(input bit rst, input bit en, input logic [3:0] we,
                      input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    s_rst = rst; s_en = en; s_we = we; s_addr = addr; s_wdata = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] addr);
    step(1'b0, 1'b1, 4'h0, addr, 32'h0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  logic [31:0] legal_pool [12];
  logic [31:0] bad_pool [6];

  initial begin
    for (int i = 0; i < 8; i++) legal_pool[i] = Base + 32'(4 * i);
    for (int i = 0; i < 4; i++) legal_pool[8 + i] = Base + 32'(4 * (16380 + i));
    bad_pool[0] = 32'h1bff_fffc; bad_pool[1] = 32'h1c01_0000; bad_pool[2] = 32'h1c00_0002;
    bad_pool[3] = 32'h0000_0000; bad_pool[4] = 32'hffff_fffc; bad_pool[5] = 32'h1c00_fffd;

    repeat (3) step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("reset rdata_valid", 32'(if1.rdata_valid), 32'h0);
    chk("reset rdata", if1.inst_sram_rdata, 32'h0);
    chk("reset err_cnt", 32'(if1.err_cnt), 32'h0);

    // Preload through the port with full-word writes.
    step(1'b0, 1'b1, 4'hF, Base, 32'h0340_0000);
    step(1'b0, 1'b1, 4'hF, Base + 32'h4, 32'h1122_3344);
    step(1'b0, 1'b1, 4'hF, Base + 32'h8, 32'h5555_6666);
    for (int i = 3; i < 12; i++) step(1'b0, 1'b1, 4'hF, legal_pool[i], $urandom);

    rd(Base);
    chk("first fetch valid", 32'(if1.rdata_valid), 32'h1);
    chk("first fetch rdata", if1.inst_sram_rdata, 32'h0340_0000);
    chk("first fetch addr", if1.rdata_addr, 32'h1c00_0000);
    chk("first fetch err", 32'(if1.addr_err), 32'h0);

    step(1'b0, 1'b1, 4'b0101, Base + 32'h4, 32'hAABB_CCDD);
    chk("byte write read-first", if1.inst_sram_rdata, 32'h1122_3344);
    rd(Base + 32'h4);
    chk("byte write merged", if1.inst_sram_rdata, 32'h11BB_33DD);

    rd(Base); rd(Base + 32'h4); rd(Base + 32'h8);
    chk("lat3 beat0 valid", 32'(if3.rdata_valid), 32'h1);
    chk("lat3 beat0 rdata", if3.inst_sram_rdata, 32'h0340_0000);
    idle();
    chk("lat3 beat1 rdata", if3.inst_sram_rdata, 32'h11BB_33DD);
    idle();
    chk("lat3 beat2 rdata", if3.inst_sram_rdata, 32'h5555_6666);
    idle();
    chk("lat3 idle valid", 32'(if3.rdata_valid), 32'h0);
    chk("lat3 idle hold", if3.inst_sram_rdata, 32'h5555_6666);

    rd(32'h1bff_fffc);
    chk("below window rdata", if1.inst_sram_rdata, 32'h0);
    chk("below window err", 32'(if1.addr_err), 32'h1);
    rd(32'h1c01_0000);
    chk("above window err", 32'(if1.addr_err), 32'h1);
    step(1'b0, 1'b1, 4'hF, 32'h1c00_0002, 32'hFFFF_FFFF);
    chk("misaligned rdata", if1.inst_sram_rdata, 32'h0);
    chk("misaligned err", 32'(if1.addr_err), 32'h1);
    chk("err_cnt after 3", 32'(if1.err_cnt), 32'h3);
    rd(Base);
    chk("memory unchanged", if1.inst_sram_rdata, 32'h0340_0000);

    rd(Base + 32'h4);
    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("lat2 flushed by reset", 32'(if2.rdata_valid), 32'h0);
    chk("err_cnt cleared", 32'(if2.err_cnt), 32'h0);
    idle();
    chk("lat2 no late pulse", 32'(if2.rdata_valid), 32'h0);
    rd(Base + 32'h4);
    idle();
    chk("lat2 after reset valid", 32'(if2.rdata_valid), 32'h1);
    chk("lat2 after reset rdata", if2.inst_sram_rdata, 32'h11BB_33DD);

    force dut1.r_err_cnt = 16'hFFFE;
    force dut2.r_err_cnt = 16'hFFFE;
    force dut3.r_err_cnt = 16'hFFFE;
    m_cnt = 16'hFFFE;
    #1;
    release dut1.r_err_cnt;
    release dut2.r_err_cnt;
    release dut3.r_err_cnt;
    for (int i = 0; i < 3; i++) begin
      rd(bad_pool[i]);
      chk("saturated err_cnt", 32'(if1.err_cnt), 32'h0000_FFFF);
      chk("saturated addr_err", 32'(if1.addr_err), 32'h1);
    end

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [3:0]  we;
      a  = ($urandom_range(0, 4) == 0) ? bad_pool[$urandom_range(0, 5)]
                                       : legal_pool[$urandom_range(0, 11)];
      we = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), we, a, $urandom);
    end
    repeat (4) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
